// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared definitions for the clock_setter block.
//   state_t      - sequencer states, in the order they are visited
//   SEG7_TABLE   - seven-segment codes for digits 0-9, active-high, bit order gfedcba
//   MIN_MOD      - minute counter modulus (60)
//   HRS_MOD      - hour counter modulus (24)
//   SETTLE_CYC   - cycles to wait after the last advance pulse before reading back
//   ENTER_CYC    - cycles the select line is held before the display is sampled
//   wrap_diff()  - (tgt - cur) mod modulus without going negative
package clock_set_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_SAMPLE  = 3'd2,
    S_ADV_MIN = 3'd3,
    S_ADV_HRS = 3'd4,
    S_SETTLE  = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [6:0] MIN_MOD    = 7'd60;
  localparam logic [6:0] HRS_MOD    = 7'd24;
  localparam logic [1:0] SETTLE_CYC = 2'd2;
  localparam logic [1:0] ENTER_CYC  = 2'd2;

  localparam logic [6:0] SEG7_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Adding the modulus before subtracting keeps the intermediate value
  // non-negative; one conditional subtraction then brings it into range.
  function automatic logic [6:0] wrap_diff(input logic [6:0] tgt,
                                           input logic [6:0] cur,
                                           input logic [6:0] modulus);
    logic [7:0] sum_s;
    sum_s = {1'b0, tgt} + {1'b0, modulus} - {1'b0, cur};
    return (sum_s >= {1'b0, modulus}) ? 7'(sum_s - {1'b0, modulus}) : sum_s[6:0];
  endfunction

endpackage

// File: rtl/clock_setter_if.sv
// clock_setter_if: request/response and clock-control bundle of clock_setter.
//   Start, Mode, TgtHrs, TgtMin      - set request (Mode 0 = time, 1 = alarm)
//   H1disp, H0disp, M1disp, M0disp   - seven-segment digits read back from the clock
//   Timeset, Alarmset, Minadv, Hrsadv - control lines driven into the clock
//   Busy, Done, Err                   - status back to the requester
// master: the system side (requester plus clock); slave: clock_setter.
interface clock_setter_if;

  logic       Start;
  logic       Mode;
  logic [4:0] TgtHrs;
  logic [5:0] TgtMin;
  logic [6:0] H1disp;
  logic [6:0] H0disp;
  logic [6:0] M1disp;
  logic [6:0] M0disp;
  logic       Timeset;
  logic       Alarmset;
  logic       Minadv;
  logic       Hrsadv;
  logic       Busy;
  logic       Done;
  logic       Err;

  modport master (
    output Start, Mode, TgtHrs, TgtMin, H1disp, H0disp, M1disp, M0disp,
    input  Timeset, Alarmset, Minadv, Hrsadv, Busy, Done, Err
  );

  modport slave (
    input  Start, Mode, TgtHrs, TgtMin, H1disp, H0disp, M1disp, M0disp,
    output Timeset, Alarmset, Minadv, Hrsadv, Busy, Done, Err
  );

endinterface

// File: rtl/clock_setter_seg7_decode.sv
// seg7_decode: maps one seven-segment code back to its decimal digit.
//   seg   - segment code, active-high, bit order gfedcba
//   digit - decoded value 0-9 (0 when the code is not a digit)
//   valid - 1 when seg is exactly one of the ten digit codes
module seg7_decode
  import clock_set_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);

  // Exact-match lookup; any partial or blank pattern is reported invalid.
  always_comb begin
    digit = 4'd0;
    valid = 1'b0;
    case (seg)
      SEG7_TABLE[0]: begin digit = 4'd0; valid = 1'b1; end
      SEG7_TABLE[1]: begin digit = 4'd1; valid = 1'b1; end
      SEG7_TABLE[2]: begin digit = 4'd2; valid = 1'b1; end
      SEG7_TABLE[3]: begin digit = 4'd3; valid = 1'b1; end
      SEG7_TABLE[4]: begin digit = 4'd4; valid = 1'b1; end
      SEG7_TABLE[5]: begin digit = 4'd5; valid = 1'b1; end
      SEG7_TABLE[6]: begin digit = 4'd6; valid = 1'b1; end
      SEG7_TABLE[7]: begin digit = 4'd7; valid = 1'b1; end
      SEG7_TABLE[8]: begin digit = 4'd8; valid = 1'b1; end
      SEG7_TABLE[9]: begin digit = 4'd9; valid = 1'b1; end
      default:       begin digit = 4'd0; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/clock_setter.sv
// clock_setter: drives an alarm clock's Timeset/Alarmset/Minadv/Hrsadv lines
// so that the selected register (time or alarm) reaches a requested hh:mm.
// The current value is read from the display, the clock is advanced by the
// wrap-corrected minute and hour distances, and the result is read back.
//   Clk   - clock shared with the alarm clock
//   Reset - synchronous, active-high
//   bus   - clock_setter_if.slave (request, display readback, control, status)
// All outputs come straight from flops whose next value is decoded from the
// next state, so each output lines up with the state it belongs to.
module clock_setter
  import clock_set_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  clock_setter_if.slave  bus
);

  state_t     state_r, state_s;
  logic       mode_r, mode_s;
  logic [4:0] tgt_hrs_r, tgt_hrs_s;
  logic [5:0] tgt_min_r, tgt_min_s;
  logic [6:0] min_left_r, min_left_s;
  logic [6:0] hrs_left_r, hrs_left_s;
  logic [1:0] cyc_r, cyc_s;

  logic timeset_r, timeset_s;
  logic alarmset_r, alarmset_s;
  logic minadv_r, minadv_s;
  logic hrsadv_r, hrsadv_s;
  logic busy_r, busy_s;
  logic done_r, done_s;
  logic err_r, err_s;
  logic sel_s;

  logic [3:0] h1_dig_s, h0_dig_s, m1_dig_s, m0_dig_s;
  logic       h1_ok_s, h0_ok_s, m1_ok_s, m0_ok_s;
  logic [6:0] cur_hrs_s, cur_min_s;
  logic [6:0] min_diff_s, hrs_diff_s;
  logic       disp_ok_s, match_s;

  seg7_decode dec_h1 (.seg(bus.H1disp), .digit(h1_dig_s), .valid(h1_ok_s));
  seg7_decode dec_h0 (.seg(bus.H0disp), .digit(h0_dig_s), .valid(h0_ok_s));
  seg7_decode dec_m1 (.seg(bus.M1disp), .digit(m1_dig_s), .valid(m1_ok_s));
  seg7_decode dec_m0 (.seg(bus.M0disp), .digit(m0_dig_s), .valid(m0_ok_s));

  assign cur_hrs_s  = ({3'b000, h1_dig_s} * 7'd10) + {3'b000, h0_dig_s};
  assign cur_min_s  = ({3'b000, m1_dig_s} * 7'd10) + {3'b000, m0_dig_s};
  assign disp_ok_s  = h1_ok_s && h0_ok_s && m1_ok_s && m0_ok_s &&
                      (cur_hrs_s <= 7'd23) && (cur_min_s <= 7'd59);
  // Distances are only consumed when disp_ok_s holds, so cur_* is in range.
  assign min_diff_s = wrap_diff({1'b0, tgt_min_r}, cur_min_s, MIN_MOD);
  assign hrs_diff_s = wrap_diff({2'b00, tgt_hrs_r}, cur_hrs_s, HRS_MOD);
  assign match_s    = disp_ok_s && (cur_hrs_s == {2'b00, tgt_hrs_r}) &&
                      (cur_min_s == {1'b0, tgt_min_r});

  // Next-state, counters, sticky error and next-output decode.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    tgt_hrs_s  = tgt_hrs_r;
    tgt_min_s  = tgt_min_r;
    min_left_s = min_left_r;
    hrs_left_s = hrs_left_r;
    cyc_s      = cyc_r;
    err_s      = err_r;
    case (state_r)
      S_IDLE: begin
        if (bus.Start) begin
          if ((bus.TgtHrs > 5'd23) || (bus.TgtMin > 6'd59)) begin
            // Out-of-range request: flag it and never touch the clock.
            err_s = 1'b1;
          end else begin
            mode_s    = bus.Mode;
            tgt_hrs_s = bus.TgtHrs;
            tgt_min_s = bus.TgtMin;
            err_s     = 1'b0;
            cyc_s     = ENTER_CYC - 2'd1;
            state_s   = S_ENTER;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ENTER: begin
        if (cyc_r == 2'd0) begin
          state_s = S_SAMPLE;
        end else begin
          cyc_s = cyc_r - 2'd1;
        end
      end
      S_SAMPLE: begin
        if (!disp_ok_s) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else begin
          min_left_s = min_diff_s;
          hrs_left_s = hrs_diff_s;
          cyc_s      = SETTLE_CYC - 2'd1;
          if (min_diff_s != 7'd0) begin
            state_s = S_ADV_MIN;
          end else if (hrs_diff_s != 7'd0) begin
            state_s = S_ADV_HRS;
          end else begin
            state_s = S_SETTLE;
          end
        end
      end
      S_ADV_MIN: begin
        // Entered with min_left >= 1; leaving on 1 gives exactly min_cnt cycles.
        min_left_s = min_left_r - 7'd1;
        if (min_left_r == 7'd1) begin
          state_s = (hrs_left_r != 7'd0) ? S_ADV_HRS : S_SETTLE;
        end else begin
          state_s = S_ADV_MIN;
        end
      end
      S_ADV_HRS: begin
        hrs_left_s = hrs_left_r - 7'd1;
        if (hrs_left_r == 7'd1) begin
          state_s = S_SETTLE;
        end else begin
          state_s = S_ADV_HRS;
        end
      end
      S_SETTLE: begin
        if (cyc_r == 2'd0) begin
          state_s = S_CHECK;
        end else begin
          cyc_s = cyc_r - 2'd1;
        end
      end
      S_CHECK: begin
        err_s   = !match_s;
        state_s = S_DONE;
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // The select line covers ENTER through CHECK so the display keeps
    // showing the register being written right up to the readback.
    sel_s      = (state_s != S_IDLE) && (state_s != S_DONE);
    timeset_s  = sel_s && !mode_s;
    alarmset_s = sel_s && mode_s;
    minadv_s   = (state_s == S_ADV_MIN);
    hrsadv_s   = (state_s == S_ADV_HRS);
    busy_s     = (state_s != S_IDLE);
    done_s     = (state_s == S_DONE);
  end

  // State, request latches, counters and output flops; Reset wins over Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      mode_r     <= 1'b0;
      tgt_hrs_r  <= 5'd0;
      tgt_min_r  <= 6'd0;
      min_left_r <= 7'd0;
      hrs_left_r <= 7'd0;
      cyc_r      <= 2'd0;
      timeset_r  <= 1'b0;
      alarmset_r <= 1'b0;
      minadv_r   <= 1'b0;
      hrsadv_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      tgt_hrs_r  <= tgt_hrs_s;
      tgt_min_r  <= tgt_min_s;
      min_left_r <= min_left_s;
      hrs_left_r <= hrs_left_s;
      cyc_r      <= cyc_s;
      timeset_r  <= timeset_s;
      alarmset_r <= alarmset_s;
      minadv_r   <= minadv_s;
      hrsadv_r   <= hrsadv_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign bus.Timeset  = timeset_r;
  assign bus.Alarmset = alarmset_r;
  assign bus.Minadv   = minadv_r;
  assign bus.Hrsadv   = hrsadv_r;
  assign bus.Busy     = busy_r;
  assign bus.Done     = done_r;
  assign bus.Err      = err_r;

endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: self-checking bench for clock_setter with a behavioural
// alarm-clock model (time and alarm registers, advance on Minadv/Hrsadv,
// optional dropped minute advance, optional corrupted digit).
module tb_clock_setter;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  clock_setter_if bus();
  clock_setter dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    int cur_h; int cur_m; int al_h; int al_m; int mode;
    int tgt_h; int tgt_m; int drop_at; int bad_seg;
    int exp_min; int exp_hrs; int exp_lat; int exp_err; int exp_h; int exp_m;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int t_h, t_m, a_h, a_m, madv_n;
  int ld_en = 0, ld_th = 0, ld_tm = 0, ld_ah = 0, ld_am = 0;
  int drop_at = -1, bad_seg = 0;
  int sel_h, sel_m;
  int n_chk = 0, n_fail = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Clock model: one advance per cycle while selected; no minute carry.
  always @(posedge Clk) begin
    if (ld_en != 0) begin
      t_h <= ld_th; t_m <= ld_tm; a_h <= ld_ah; a_m <= ld_am; madv_n <= 0;
    end else begin
      if ((bus.Timeset || bus.Alarmset) && bus.Minadv) begin
        madv_n <= madv_n + 1;
        if (madv_n != drop_at) begin
          if (bus.Alarmset) a_m <= (a_m + 1) % 60;
          else              t_m <= (t_m + 1) % 60;
        end
      end
      if ((bus.Timeset || bus.Alarmset) && bus.Hrsadv) begin
        if (bus.Alarmset) a_h <= (a_h + 1) % 24;
        else              t_h <= (t_h + 1) % 24;
      end
    end
  end

  // Display shows the alarm register while Alarmset is held, else the time.
  always_comb begin
    sel_h = bus.Alarmset ? a_h : t_h;
    sel_m = bus.Alarmset ? a_m : t_m;
    bus.H1disp = seg_of(sel_h / 10);
    bus.H0disp = seg_of(sel_h % 10);
    bus.M1disp = seg_of(sel_m / 10);
    bus.M0disp = (bad_seg != 0) ? 7'b0000000 : seg_of(sel_m % 10);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Loads the clock model, then raises Start for the cycle that follows.
  task automatic start_op(input int th, input int tm, input int ah, input int am,
                          input int mode, input int gh, input int gm);
    @(posedge Clk); #1;
    ld_en = 1; ld_th = th; ld_tm = tm; ld_ah = ah; ld_am = am;
    @(posedge Clk); #1;
    ld_en = 0;
    bus.Start = 1'b1; bus.Mode = (mode != 0);
    bus.TgtHrs = 5'(gh); bus.TgtMin = 6'(gm);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0, nmin = 0, nhrs = 0, nsel = 0, nother = 0, order_bad = 0;
    int found = 0, hseen = 0, mfirst = -1, mlast = -1, hfirst = -1, hlast = -1;
    vec_t e;
    drop_at = v.drop_at; bad_seg = v.bad_seg;
    start_op(v.cur_h, v.cur_m, v.al_h, v.al_m, v.mode, v.tgt_h, v.tgt_m);
    sb.push_back(v);
    for (int n = 1; n <= 300; n++) begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(negedge Clk);
      if (bus.Hrsadv) begin
        nhrs++; hseen = 1; if (hfirst < 0) hfirst = n; hlast = n;
      end
      if (bus.Minadv) begin
        nmin++; if (mfirst < 0) mfirst = n; mlast = n;
        if (hseen != 0) order_bad++;
      end
      if ((v.mode != 0) ? bus.Alarmset : bus.Timeset) nsel++;
      if ((v.mode != 0) ? bus.Timeset : bus.Alarmset) nother++;
      if (bus.Done) begin found = 1; lat = n; break; end
    end
    if (found == 0) begin
      n_chk++; n_fail++;
      $display("FAIL vec%0d_timeout: actual no Done required Done", idx);
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d_latency", idx), lat, e.exp_lat);
      chk($sformatf("vec%0d_err", idx), int'(bus.Err), e.exp_err);
      chk($sformatf("vec%0d_minadv_cycles", idx), nmin, e.exp_min);
      chk($sformatf("vec%0d_hrsadv_cycles", idx), nhrs, e.exp_hrs);
      chk($sformatf("vec%0d_select_cycles", idx), nsel, e.exp_lat - 1);
      chk($sformatf("vec%0d_other_select", idx), nother, 0);
      chk($sformatf("vec%0d_adv_overlap", idx), order_bad, 0);
      chk($sformatf("vec%0d_minadv_contig", idx), (nmin > 0) ? (mlast - mfirst + 1) : 0, e.exp_min);
      chk($sformatf("vec%0d_hrsadv_contig", idx), (nhrs > 0) ? (hlast - hfirst + 1) : 0, e.exp_hrs);
      chk($sformatf("vec%0d_result_hrs", idx), (e.mode != 0) ? a_h : t_h, e.exp_h);
      chk($sformatf("vec%0d_result_min", idx), (e.mode != 0) ? a_m : t_m, e.exp_m);
      @(negedge Clk);
      chk($sformatf("vec%0d_done_pulse", idx), int'(bus.Done), 0);
      chk($sformatf("vec%0d_idle_busy", idx), int'(bus.Busy), 0);
    end
    drop_at = -1; bad_seg = 0;
  endtask

  function automatic int ctrl_bits();
    return int'({bus.Timeset, bus.Alarmset, bus.Minadv, bus.Hrsadv});
  endfunction

  initial begin
    int found, lat, extra;
    //          cur    alarm  md tgt    drop bad  min hrs lat err res
    vecs[0] = '{0,  0,  0, 0,  0, 7,  50, -1, 0,  50, 7,  64, 0, 7,  50};
    vecs[1] = '{7,  50, 0, 0,  1, 8,  1,  -1, 0,  1,  8,  16, 0, 8,  1};
    vecs[2] = '{23, 59, 0, 0,  0, 0,  0,  -1, 0,  1,  1,  9,  0, 0,  0};
    vecs[3] = '{12, 34, 0, 0,  0, 12, 34, -1, 0,  0,  0,  7,  0, 12, 34};
    vecs[4] = '{0,  0,  0, 0,  0, 0,  5,  2,  0,  5,  0,  12, 1, 0,  4};
    vecs[5] = '{10, 45, 0, 0,  0, 3,  20, -1, 0,  35, 17, 59, 0, 3,  20};
    vecs[6] = '{10, 45, 0, 0,  0, 11, 0,  -1, 1,  0,  0,  4,  1, 10, 45};
    vecs[7] = '{5,  5, 22, 10, 1, 1,  9,  -1, 0,  59, 3,  69, 0, 1,  9};

    Reset = 1'b1; bus.Start = 1'b0; bus.Mode = 1'b0;
    bus.TgtHrs = 5'd0; bus.TgtMin = 6'd0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_ctrl", ctrl_bits(), 0);
    chk("reset_busy", int'(bus.Busy), 0);
    chk("reset_done", int'(bus.Done), 0);
    chk("reset_err", int'(bus.Err), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Out-of-range request: Err next cycle, nothing driven, stays idle.
    chk("badreq_err_before", int'(bus.Err), 0);
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.Mode = 1'b0; bus.TgtHrs = 5'd5; bus.TgtMin = 6'd60;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    chk("badreq_err", int'(bus.Err), 1);
    chk("badreq_busy", int'(bus.Busy), 0);
    chk("badreq_ctrl", ctrl_bits(), 0);
    extra = 0;
    repeat (5) begin
      @(negedge Clk);
      extra += ctrl_bits() + int'(bus.Busy);
    end
    chk("badreq_quiet", extra, 0);

    // A valid request clears the sticky error.
    start_op(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    chk("err_clear", int'(bus.Err), 0);
    chk("err_clear_busy", int'(bus.Busy), 1);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (bus.Done) begin found = 1; break; end
    end
    chk("err_clear_done_seen", found, 1);

    // Second Start while busy is ignored.
    start_op(0, 0, 0, 0, 0, 0, 3);
    found = 0; lat = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge Clk); #1;
      bus.Start = (n == 2);
      if (n == 2) begin bus.TgtHrs = 5'd5; bus.TgtMin = 6'd0; end
      @(negedge Clk);
      if (bus.Done) begin found = 1; lat = n; break; end
    end
    chk("busy_start_latency", lat, 10);
    chk("busy_start_min", t_m, 3);
    chk("busy_start_hrs", t_h, 0);
    extra = 0;
    repeat (20) begin
      @(negedge Clk);
      extra += int'(bus.Done) + int'(bus.Busy);
    end
    chk("busy_start_no_rerun", extra, 0);

    // Reset in the middle of ADV_MIN.
    start_op(0, 0, 0, 0, 0, 0, 30);
    found = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(negedge Clk);
      if (bus.Minadv) begin found = 1; break; end
    end
    chk("rst_reach_advmin", found, 1);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_ctrl", ctrl_bits(), 0);
    chk("rst_mid_busy", int'(bus.Busy), 0);
    chk("rst_mid_done_err", int'(bus.Done) + int'(bus.Err), 0);
    extra = 0;
    repeat (5) begin
      @(negedge Clk);
      extra += ctrl_bits() + int'(bus.Busy) + int'(bus.Done);
    end
    chk("rst_mid_stays_idle", extra, 0);

    // Reset and Start in the same cycle: Reset wins.
    @(posedge Clk); #1;
    Reset = 1'b1; bus.Start = 1'b1; bus.TgtHrs = 5'd1; bus.TgtMin = 6'd0;
    @(posedge Clk); #1;
    Reset = 1'b0; bus.Start = 1'b0;
    @(negedge Clk);
    chk("rst_prio_busy", int'(bus.Busy), 0);
    chk("rst_prio_ctrl", ctrl_bits(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_setter.md
CLOCK_SETTER -- requirements
Module: clock_setter

Interface
REQ-001 SHALL have port Clk, input, 1: single clock; the same clock as the alarm clock's Pulse.
REQ-002 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1: one-cycle request to set a target time.
REQ-004 SHALL have port Mode, input, 1: 0 = set current time (Timeset), 1 = set alarm (Alarmset); sampled with Start.
REQ-005 SHALL have ports TgtHrs (input, 5) and TgtMin (input, 6): target hours 0-23 and minutes 0-59; sampled with Start.
REQ-006 SHALL have ports H1disp, H0disp, M1disp, M0disp, each input, 7: seven-segment digits read back from the clock.
REQ-007 SHALL have ports Timeset, Alarmset, Minadv and Hrsadv, each output, 1: control lines driven into the clock.
REQ-008 SHALL have ports Busy (output, 1: operation in progress), Done (output, 1: one-cycle completion pulse) and Err (output, 1: sticky failure flag).

Function
REQ-009 SHALL assume the clock advances its minute or hour counter by one per Clk cycle while (Timeset|Alarmset) & Minadv/Hrsadv, with no minute-to-hour carry.
REQ-010 SHALL implement the FSM IDLE -> ENTER -> SAMPLE -> ADV_MIN -> ADV_HRS -> SETTLE -> CHECK -> DONE -> IDLE.
REQ-011 SHALL, in IDLE, accept Start only when Busy=0, latch Mode/TgtHrs/TgtMin, and clear Err.
REQ-012 SHALL, on Start with TgtHrs>23 or TgtMin>59, stay in IDLE, assert Err next cycle and drive no control lines.
REQ-013 SHALL, in ENTER, assert Timeset (Mode=0) or Alarmset (Mode=1) and hold it for 2 cycles so the display shows the selected register.
REQ-014 SHALL keep the selected Timeset/Alarmset asserted in every state from ENTER through CHECK, and deassert it in DONE.
REQ-015 SHALL, in SAMPLE, decode all four digits to cur_hrs = 10*H1+H0 and cur_min = 10*M1+M0; an invalid segment code, cur_hrs>23 or cur_min>59 -> Err=1, go to DONE.
REQ-016 SHALL compute min_cnt = (TgtMin - cur_min) mod 60 and hrs_cnt = (TgtHrs - cur_hrs) mod 24 using unsigned wrap-correct arithmetic (add 60/24 when negative).
REQ-017 SHALL, in ADV_MIN, hold Minadv=1 for exactly min_cnt consecutive cycles; min_cnt=0 -> skip the state with Minadv never asserted.
REQ-018 SHALL, in ADV_HRS, hold Hrsadv=1 for exactly hrs_cnt consecutive cycles; hrs_cnt=0 -> skip; Minadv and Hrsadv never both high.
REQ-019 SHALL, in SETTLE, wait 2 cycles with Minadv=Hrsadv=0.
REQ-020 SHALL, in CHECK, re-decode the display; a mismatch with the target -> Err=1.
REQ-021 SHALL, in DONE, pulse Done for 1 cycle, then return to IDLE; Busy=1 in every state except IDLE.
REQ-022 SHALL ignore Start while Busy; total latency from Start to Done = 2+1+min_cnt+hrs_cnt+2+1+1 cycles.
REQ-023 SHALL hold Err until the next accepted Start or Reset.

Reset
REQ-024 SHALL, on Reset=1 at a Clk edge (including mid-operation), go to IDLE with Timeset=Alarmset=Minadv=Hrsadv=Busy=Done=Err=0 and counters cleared.
REQ-025 SHALL give Reset priority over Start in the same cycle.

Structure
REQ-026 SHALL place the FSM state enum, the seven-segment digit table (active-high, bit order gfedcba, 0-9) and constants MIN_MOD=60, HRS_MOD=24, SETTLE_CYC=2 in shared package clock_set_pkg.
REQ-027 SHALL instantiate sub-module seg7_decode (7-bit segment in -> 4-bit digit + valid) four times.

Verification
REQ-028 SHALL cover: clock at 00:00, Start Mode=0 target 07:50 -> Minadv high 50 cycles, then Hrsadv high 7 cycles, Done, Err=0, display 07:50.
REQ-029 SHALL cover: current 07:50, Start Mode=1 target 08:01 with alarm at 00:00 -> Alarmset held, 1 Minadv cycle, 8 Hrsadv cycles, Done, Err=0.
REQ-030 SHALL cover wrap-around: current 23:59, target 00:00 -> min_cnt=1, hrs_cnt=1, Done, display 00:00.
REQ-031 SHALL cover: target equal to current 12:34 -> no Minadv/Hrsadv, Done 7 cycles after Start.
REQ-032 SHALL cover: TgtMin=60 -> Err=1, Busy=0, no control lines asserted; second Start during Busy ignored.
REQ-033 SHALL cover: Reset asserted during ADV_MIN -> next cycle all outputs 0, IDLE; a bench clock model that drops one advance -> Err=1 at CHECK.
